// File: rtl/gsim_mem_arbiter.sv
// Round-robin arbiter sharing one matrix-memory read port between two GSIM engines.
// Define GSIM_ARB_DOUT_REG_EN to register o_dout / o_dout_vld0/1 (one cycle of added latency).
module gsim_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req0,
    input  logic                   i_req1,
    input  logic [ADDR_W-1:0]      i_addr0,
    input  logic [ADDR_W-1:0]      i_addr1,
    output logic                   o_gnt0,
    output logic                   o_gnt1,
    output logic                   o_mem_rreq,
    output logic [ADDR_W-1:0]      o_mem_addr,
    input  logic                   i_mem_rrdy,
    input  logic [DATA_W-1:0]      i_mem_dout,
    input  logic                   i_mem_dout_vld,
    output logic [DATA_W-1:0]      o_dout,
    output logic                   o_dout_vld0,
    output logic                   o_dout_vld1,
    output logic [$clog2(DEPTH):0] o_outstanding,
    output logic                   o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             prio;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [DEPTH-1:0] tag_mem;

    logic full;
    logic empty;
    logic elig0;
    logic elig1;
    logic sel;
    logic issue;
    logic pop;
    logic err_set;
    logic head_id;

    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        elig0      = i_req0 && !full;
        elig1      = i_req1 && !full;
        sel        = (elig0 && elig1) ? prio : elig1;
        o_mem_rreq = elig0 || elig1;
        o_mem_addr = '0;
        if (o_mem_rreq) begin
            o_mem_addr = sel ? i_addr1 : i_addr0;
        end
        issue   = o_mem_rreq && i_mem_rrdy;
        o_gnt0  = issue && !sel;
        o_gnt1  = issue && sel;
        // A return with nothing in flight is a protocol error and is dropped.
        pop     = i_mem_dout_vld && !empty;
        err_set = i_mem_dout_vld && empty;
        head_id = tag_mem[rd_ptr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prio   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (issue) begin
                prio   <= !sel;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Owner tags only need to be valid between push and pop, so no reset.
    always_ff @(posedge i_clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= sel;
        end
    end

    assign o_outstanding = count;
    assign o_err         = err;

`ifdef GSIM_ARB_DOUT_REG_EN
    logic [DATA_W-1:0] dout_p1;
    logic              vld0_p1;
    logic              vld1_p1;

    // Return stage -> output register stage
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dout_p1 <= '0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            vld0_p1 <= pop && !head_id;
            vld1_p1 <= pop && head_id;
            if (pop) begin
                dout_p1 <= i_mem_dout;
            end
        end
    end

    assign o_dout      = dout_p1;
    assign o_dout_vld0 = vld0_p1;
    assign o_dout_vld1 = vld1_p1;
`else
    assign o_dout      = i_mem_dout;
    assign o_dout_vld0 = pop && !head_id;
    assign o_dout_vld1 = pop && head_id;
`endif

endmodule

// File: tb/tb_gsim_mem_arbiter.sv
// Directed bench for gsim_mem_arbiter with a fixed-latency memory model.
module tb_gsim_mem_arbiter;

`ifdef GSIM_ARB_DOUT_REG_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic         clk;
    logic         i_reset;
    logic         i_req0, i_req1;
    logic [9:0]   i_addr0, i_addr1;
    logic         o_gnt0, o_gnt1;
    logic         o_mem_rreq;
    logic [9:0]   o_mem_addr;
    logic         i_mem_rrdy;
    logic [255:0] i_mem_dout;
    logic         i_mem_dout_vld;
    logic [255:0] o_dout;
    logic         o_dout_vld0, o_dout_vld1;
    logic [2:0]   o_outstanding;
    logic         o_err;

    gsim_mem_arbiter dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr),
        .i_mem_rrdy(i_mem_rrdy), .i_mem_dout(i_mem_dout),
        .i_mem_dout_vld(i_mem_dout_vld),
        .o_dout(o_dout), .o_dout_vld0(o_dout_vld0), .o_dout_vld1(o_dout_vld1),
        .o_outstanding(o_outstanding), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 2;
    logic         inj_vld = 1'b0;
    logic [255:0] inj_data = '0;
    logic         sched_vld [64];
    logic [255:0] sched_data [64];

    function automatic logic [255:0] row(input logic [9:0] a);
        return {a, 118'h0, ~a, 118'h0};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs at negedge, model memory returns and captures issues.
    task automatic drive(input logic rst, input logic r0, input logic [9:0] a0,
                         input logic r1, input logic [9:0] a1, input logic rdy);
        int slot;
        @(negedge clk);
        i_reset    = rst;
        i_req0     = r0;
        i_addr0    = a0;
        i_req1     = r1;
        i_addr1    = a1;
        i_mem_rrdy = rdy;
        slot = cyc % 64;
        i_mem_dout_vld = sched_vld[slot] | inj_vld;
        i_mem_dout     = sched_vld[slot] ? sched_data[slot] : (inj_vld ? inj_data : '0);
        sched_vld[slot] = 1'b0;
        #1;
        if (o_mem_rreq && i_mem_rrdy) begin
            sched_vld[(cyc + lat) % 64]  = 1'b1;
            sched_data[(cyc + lat) % 64] = row(o_mem_addr);
        end
        cyc++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
    endtask

    initial begin
        int r;
        logic v0, v1;
        for (int i = 0; i < 64; i++) begin
            sched_vld[i]  = 1'b0;
            sched_data[i] = '0;
        end
        i_reset = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0; i_addr0 = '0; i_addr1 = '0;
        i_mem_rrdy = 1'b0; i_mem_dout = '0; i_mem_dout_vld = 1'b0;

        drive(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
        idle();
        chk("rst_outstanding", o_outstanding, 0);
        chk("rst_err", o_err, 0);
        chk("rst_vld0", o_dout_vld0, 0);
        chk("rst_vld1", o_dout_vld1, 0);
        chk("rst_rreq", o_mem_rreq, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_dout", o_dout, 0);

        // Single read, latency 2
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, k == 0, 10'h011, 1'b0, 10'h000, 1'b1);
            if (k == 0) begin
                chk("t1_gnt0", o_gnt0, 1);
                chk("t1_gnt1", o_gnt1, 0);
                chk("t1_addr", o_mem_addr, 10'h011);
            end
            chk("t1_outstanding", o_outstanding, (k == 1 || k == 2) ? 1 : 0);
            chk("t1_vld0", o_dout_vld0, k == 2 + RL);
            chk("t1_vld1", o_dout_vld1, 0);
            if (k == 2 + RL) chk("t1_dout", o_dout, row(10'h011));
        end

        // Alternating grants with both engines requesting
        drive(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, k < 6, 10'h020, k < 6, 10'h120, 1'b1);
            chk("t2_gnt0", o_gnt0, (k < 6) && (k % 2 == 0));
            chk("t2_gnt1", o_gnt1, (k < 6) && (k % 2 == 1));
            if (k < 6) chk("t2_addr", o_mem_addr, (k % 2 == 0) ? 10'h020 : 10'h120);
            r  = k - 2 - RL;
            v0 = (r >= 0) && (r < 6) && (r % 2 == 0);
            v1 = (r >= 0) && (r < 6) && (r % 2 == 1);
            chk("t2_vld0", o_dout_vld0, v0);
            chk("t2_vld1", o_dout_vld1, v1);
            if (v0 || v1) chk("t2_dout", o_dout, row(v0 ? 10'h020 : 10'h120));
            chk("t2_outstanding", o_outstanding,
                (k == 0) ? 0 : (k == 1) ? 1 : (k <= 6) ? 2 : (k == 7) ? 1 : 0);
        end

        // Stall with prio=1: selection must hold
        drive(1'b0, 1'b1, 10'h011, 1'b0, 10'h000, 1'b1);
        chk("t3_pre_gnt0", o_gnt0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 10'h020, 1'b1, 10'h120, 1'b0);
            chk("t3_stall_rreq", o_mem_rreq, 1);
            chk("t3_stall_addr", o_mem_addr, 10'h120);
            chk("t3_stall_gnt0", o_gnt0, 0);
            chk("t3_stall_gnt1", o_gnt1, 0);
        end
        drive(1'b0, 1'b1, 10'h020, 1'b1, 10'h120, 1'b1);
        chk("t3_gnt1", o_gnt1, 1);
        chk("t3_gnt1_g0", o_gnt0, 0);
        drive(1'b0, 1'b1, 10'h020, 1'b1, 10'h120, 1'b1);
        chk("t3_next_gnt0", o_gnt0, 1);
        chk("t3_next_addr", o_mem_addr, 10'h020);
        for (int k = 0; k < 5; k++) idle();
        chk("t3_drained", o_outstanding, 0);

        // Long latency: FIFO fills at DEPTH, no pop bypass
        lat = 10;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 10'h033, 1'b0, 10'h000, 1'b1);
            chk("t4_gnt0", o_gnt0, (k < 4) || (k == 11));
            chk("t4_rreq", o_mem_rreq, (k < 4) || (k == 11));
            chk("t4_outstanding", o_outstanding, (k <= 4) ? k : (k <= 10) ? 4 : 3);
        end
        for (int k = 0; k < 14; k++) idle();
        chk("t4_drained", o_outstanding, 0);
        chk("t4_err", o_err, 0);

        // Spurious return with empty FIFO
        lat = 2;
        inj_vld = 1'b1;
        inj_data = row(10'h3ff);
        idle();
        inj_vld = 1'b0;
        chk("t5_vld0_a", o_dout_vld0, 0);
        chk("t5_vld1_a", o_dout_vld1, 0);
        chk("t5_err_a", o_err, 0);
        idle();
        chk("t5_vld0_b", o_dout_vld0, 0);
        chk("t5_vld1_b", o_dout_vld1, 0);
        chk("t5_err_b", o_err, 1);
        chk("t5_outstanding", o_outstanding, 0);
        for (int k = 0; k < 3; k++) idle();
        chk("t5_err_sticky", o_err, 1);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        idle();
        chk("t5_err_cleared", o_err, 0);

        // Reset with reads in flight
        lat = 4;
        drive(1'b0, 1'b1, 10'h044, 1'b0, 10'h000, 1'b1);
        chk("t6_gnt0_a", o_gnt0, 1);
        drive(1'b0, 1'b1, 10'h055, 1'b0, 10'h000, 1'b1);
        chk("t6_gnt0_b", o_gnt0, 1);
        chk("t6_addr_b", o_mem_addr, 10'h055);
        drive(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1);
        chk("t6_outstanding_pre", o_outstanding, 2);
        idle();
        chk("t6_outstanding_post", o_outstanding, 0);
        chk("t6_err_post", o_err, 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t6_late_vld0", o_dout_vld0, 0);
            chk("t6_late_vld1", o_dout_vld1, 0);
            chk("t6_late_err", o_err, k > 0);
        end
        chk("t6_late_outstanding", o_outstanding, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
